mem_io_responder: RTL and testbench

- Responder end of the CPU byte-wide memory bus: models the 128 KB RAM and the memory-mapped I/O port seen by cpu.
- Serves reads with one-cycle registered latency and performs writes in the same cycle.
- Buffers UART output in a TX FIFO and UART input in an RX FIFO.
- Maintains the running cycle counter and signals program stop.
- Drives cpu.rdy_in to throttle the CPU when the TX FIFO is full.

---
 rtl/mem_io_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the CPU byte-wide memory bus.
// Provides the 128 KB RAM, the UART TX/RX FIFOs, the free-running cycle
// counter with its snapshot register, and the program-stop pulse.
// cpu_rdy throttles the CPU whenever the TX FIFO has no free slot.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG2  = 4,
    parameter int RX_DEPTH_LOG2  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,

    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,

    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,

    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,

    output logic        program_stop
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
    localparam int TX_DEPTH  = 1 << TX_DEPTH_LOG2;
    localparam int RX_DEPTH  = 1 << RX_DEPTH_LOG2;

    // Pointer arithmetic constants; pointers carry one extra wrap bit.
    localparam logic [TX_DEPTH_LOG2:0] TX_FULL    = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
    localparam logic [TX_DEPTH_LOG2:0] TX_PTR_ONE = {{TX_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [RX_DEPTH_LOG2:0] RX_FULL    = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
    localparam logic [RX_DEPTH_LOG2:0] RX_PTR_ONE = {{RX_DEPTH_LOG2{1'b0}}, 1'b1};

    // Memory-mapped I/O register addresses (only the low 18 address bits decode).
    localparam logic [17:0] IO_UART  = 18'h3_0000;
    localparam logic [17:0] IO_CNT_0 = 18'h3_0004;
    localparam logic [17:0] IO_CNT_1 = 18'h3_0005;
    localparam logic [17:0] IO_CNT_2 = 18'h3_0006;
    localparam logic [17:0] IO_CNT_3 = 18'h3_0007;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [17:0]               bus_addr;
    logic                      is_io;
    logic                      bus_active;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      unused_addr_bits;

    assign bus_addr         = cpu_a[17:0];
    assign is_io            = (bus_addr[17:16] == 2'b11);
    assign ram_idx          = cpu_a[RAM_ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^cpu_a[31:18];

    // The whole bus is frozen while the CPU is throttled.
    assign bus_active = cpu_rdy;

    logic bus_rd;
    logic ram_wr;
    logic uart_rd;
    logic uart_wr;
    logic stop_wr;
    logic snap_rd;

    assign bus_rd  = bus_active && !cpu_wr;
    assign ram_wr  = bus_active &&  cpu_wr && !is_io;
    assign uart_rd = bus_rd && (bus_addr == IO_UART);
    assign uart_wr = bus_active && cpu_wr && (bus_addr == IO_UART) && (cpu_dout != 8'h00);
    assign stop_wr = bus_active && cpu_wr && (bus_addr == IO_CNT_0);
    assign snap_rd = bus_rd && (bus_addr == IO_CNT_0);

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [7:0] ram_mem [RAM_DEPTH];

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_wr) begin
            ram_mem[ram_idx] <= cpu_dout;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (CPU -> UART)
    // ------------------------------------------------------------------
    logic [7:0]             tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG2:0] tx_wr_ptr;
    logic [TX_DEPTH_LOG2:0] tx_rd_ptr;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic                   tx_push;
    logic                   tx_pop;
    logic [7:0]             tx_push_data;

    assign tx_count     = tx_wr_ptr - tx_rd_ptr;
    assign tx_valid     = (tx_count != '0);
    assign tx_data      = tx_mem[tx_rd_ptr[TX_DEPTH_LOG2-1:0]];
    assign tx_push      = uart_wr || stop_wr;
    assign tx_pop       = tx_valid && tx_ready;
    assign tx_push_data = stop_wr ? 8'h00 : cpu_dout;

    // A full TX FIFO stalls the CPU, so a push can never overflow it.
    assign cpu_rdy = (tx_count != TX_FULL);

    // TX storage write; pushes only happen while a slot is free.
    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr[TX_DEPTH_LOG2-1:0]] <= tx_push_data;
        end
    end

    // TX pointer bookkeeping; reset flushes any buffered bytes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (UART -> CPU)
    // ------------------------------------------------------------------
    logic [7:0]             rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG2:0] rx_wr_ptr;
    logic [RX_DEPTH_LOG2:0] rx_rd_ptr;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic                   rx_empty;
    logic                   rx_push;
    logic                   rx_pop;
    logic [7:0]             rx_head;

    assign rx_count = rx_wr_ptr - rx_rd_ptr;
    assign rx_empty = (rx_count == '0);
    assign rx_ready = (rx_count != RX_FULL);
    assign rx_push  = rx_valid && rx_ready;
    assign rx_head  = rx_mem[rx_rd_ptr[RX_DEPTH_LOG2-1:0]];

    // Popping is judged on the registered count, so a byte arriving in the
    // same cycle as a read of an empty FIFO stays queued for the next read.
    assign rx_pop = uart_rd && !rx_empty;

    // RX storage write from the UART side.
    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr[RX_DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    // RX pointer bookkeeping; reset discards any received bytes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter, snapshot and program stop
    // ------------------------------------------------------------------
    logic [31:0] cycle_count;
    logic [31:0] count_snapshot;
    logic        halted;

    // Free-running counter; keeps counting through CPU stalls and
    // freezes from the cycle after the first stop write.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_count <= 32'd0;
            halted      <= 1'b0;
        end else begin
            if (!halted) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (stop_wr) begin
                halted <= 1'b1;
            end
        end
    end

    // Snapshot taken on a byte-0 read so the upper bytes read coherently later.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_snapshot <= 32'd0;
        end else if (snap_rd) begin
            count_snapshot <= cycle_count;
        end
    end

    // One-cycle stop pulse for every stop write, repeated writes included.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            program_stop <= 1'b0;
        end else begin
            program_stop <= stop_wr;
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    logic [7:0] io_rdata;

    // I/O read mux; byte 0 of the counter comes live because the snapshot
    // is being loaded in the same cycle.
    always_comb begin
        io_rdata = 8'h00;
        case (bus_addr)
            IO_UART:  io_rdata = rx_empty ? 8'h00 : rx_head;
            IO_CNT_0: io_rdata = cycle_count[7:0];
            IO_CNT_1: io_rdata = count_snapshot[15:8];
            IO_CNT_2: io_rdata = count_snapshot[23:16];
            IO_CNT_3: io_rdata = count_snapshot[31:24];
            default:  io_rdata = 8'h00;
        endcase
    end

    // Registered read data: one cycle of latency, held while stalled or writing.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_din <= 8'h00;
        end else if (bus_rd) begin
            if (is_io) begin
                cpu_din <= io_rdata;
            end else begin
                cpu_din <= ram_mem[ram_idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] tx_seen [$];
    int         stop_pulses = 0;

    localparam logic [31:0] IDLE_ADDR = 32'h0003_000C;

    mem_io_responder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .cpu_a        (cpu_a),
        .cpu_wr       (cpu_wr),
        .cpu_dout     (cpu_dout),
        .cpu_din      (cpu_din),
        .cpu_rdy      (cpu_rdy),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .program_stop (program_stop)
    );

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    // Record bytes leaving the TX FIFO and stop pulses, half a cycle from the edge.
    always @(negedge clk_in) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_seen.push_back(tx_data);
        if (program_stop === 1'b1) stop_pulses++;
    end

    task automatic bus_idle();
        cpu_a    = IDLE_ADDR;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        cpu_a    = a;
        cpu_wr   = 1'b1;
        cpu_dout = d;
        @(posedge clk_in);
        #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
        cpu_a  = a;
        cpu_wr = 1'b0;
        @(posedge clk_in);
        #1;
        d = cpu_din;
        bus_idle();
    endtask

    task automatic do_reset();
        bus_idle();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        rst_in   = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_compared++;
        if (cpu_din !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_cpu_din: got 0x%02h, expected 0x00", cpu_din); end
        n_compared++;
        if (tx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tx_valid: got %b, expected 0", tx_valid); end
        n_compared++;
        if (rx_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_rx_ready: got %b, expected 1", rx_ready); end
        n_compared++;
        if (cpu_rdy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_cpu_rdy: got %b, expected 1", cpu_rdy); end
        n_compared++;
        if (program_stop !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_program_stop: got %b, expected 0", program_stop); end
    endtask

    task automatic test_ram();
        logic [7:0] rd;
        do_reset();
        bus_write(32'h0000_1234, 8'hA5);
        bus_read(32'h0000_1234, rd);
        n_compared++;
        if (rd !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL ram_rd_01234: got 0x%02h, expected 0xa5", rd); end
        bus_read(32'h0002_1234, rd);
        n_compared++;
        if (rd !== 8'hA5) begin n_mismatched++; $display("[TB] FAIL ram_alias_21234: got 0x%02h, expected 0xa5", rd); end
        bus_write(32'h0001_FFFF, 8'h3C);
        bus_write(32'h0000_0000, 8'h5A);
        bus_read(32'h0001_FFFF, rd);
        n_compared++;
        if (rd !== 8'h3C) begin n_mismatched++; $display("[TB] FAIL ram_top_1ffff: got 0x%02h, expected 0x3c", rd); end
        bus_read(32'h0002_0000, rd);
        n_compared++;
        if (rd !== 8'h5A) begin n_mismatched++; $display("[TB] FAIL ram_alias_20000: got 0x%02h, expected 0x5a", rd); end
        bus_read(32'h0003_1234, rd);
        n_compared++;
        if (rd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL io_rd_31234: got 0x%02h, expected 0x00", rd); end
        bus_write(32'h0003_0008, 8'h55);
        n_compared++;
        if (tx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL io_wr_30008_ignored: tx_valid got %b, expected 0", tx_valid); end
    endtask

    task automatic test_tx_and_stop();
        logic [7:0] rd;
        logic [7:0] exp_tx [4];
        logic [7:0] got;
        exp_tx[0] = 8'h48; exp_tx[1] = 8'h69; exp_tx[2] = 8'h00; exp_tx[3] = 8'h00;
        do_reset();
        tx_seen.delete();
        stop_pulses = 0;
        tx_ready = 1'b1;
        bus_write(32'h0003_0000, 8'h48);
        bus_write(32'h0003_0000, 8'h69);
        bus_write(32'h0003_0000, 8'h00);
        idle_cycles(46);
        n_compared++;
        if (tx_seen.size() != 2) begin n_mismatched++; $display("[TB] FAIL tx_hi_count: got %0d, expected 2", tx_seen.size()); end
        // Stop write lands on the 50th edge after reset, so the counter freezes at 50.
        bus_write(32'h0003_0004, 8'h00);
        n_compared++;
        if (program_stop !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stop_pulse_high: got %b, expected 1", program_stop); end
        idle_cycles(1);
        n_compared++;
        if (program_stop !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stop_pulse_low: got %b, expected 0", program_stop); end
        idle_cycles(100);
        n_compared++;
        if (stop_pulses != 1) begin n_mismatched++; $display("[TB] FAIL stop_pulse_count: got %0d, expected 1", stop_pulses); end
        bus_read(32'h0003_0004, rd);
        n_compared++;
        if (rd !== 8'h32) begin n_mismatched++; $display("[TB] FAIL frozen_cnt_b0: got 0x%02h, expected 0x32", rd); end
        bus_read(32'h0003_0005, rd);
        n_compared++;
        if (rd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL frozen_cnt_b1: got 0x%02h, expected 0x00", rd); end
        bus_write(32'h0003_0004, 8'h00);
        idle_cycles(3);
        n_compared++;
        if (stop_pulses != 2) begin n_mismatched++; $display("[TB] FAIL repeat_stop_pulses: got %0d, expected 2", stop_pulses); end
        n_compared++;
        if (tx_seen.size() != 4) begin n_mismatched++; $display("[TB] FAIL tx_stream_count: got %0d, expected 4", tx_seen.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < tx_seen.size()) ? tx_seen[i] : 8'hXX;
            n_compared++;
            if (got !== exp_tx[i]) begin n_mismatched++; $display("[TB] FAIL tx_stream[%0d]: got 0x%02h, expected 0x%02h", i, got, exp_tx[i]); end
        end
    endtask

    task automatic test_tx_full();
        logic [7:0] rd;
        logic [7:0] got;
        do_reset();
        bus_write(32'h0000_0100, 8'h11);
        for (int i = 1; i <= 15; i++) bus_write(32'h0003_0000, 8'(i));
        n_compared++;
        if (cpu_rdy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rdy_after_15: got %b, expected 1", cpu_rdy); end
        bus_write(32'h0003_0000, 8'd16);
        n_compared++;
        if (cpu_rdy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rdy_after_16: got %b, expected 0", cpu_rdy); end
        bus_write(32'h0003_0000, 8'd17);
        bus_write(32'h0000_0100, 8'hEE);
        n_compared++;
        if (cpu_rdy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rdy_still_low: got %b, expected 0", cpu_rdy); end
        n_compared++;
        if (tx_data !== 8'h01) begin n_mismatched++; $display("[TB] FAIL tx_head_stable: got 0x%02h, expected 0x01", tx_data); end
        tx_seen.delete();
        tx_ready = 1'b1;
        idle_cycles(1);
        n_compared++;
        if (cpu_rdy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rdy_after_drain: got %b, expected 1", cpu_rdy); end
        idle_cycles(20);
        n_compared++;
        if (tx_seen.size() != 16) begin n_mismatched++; $display("[TB] FAIL drain_count: got %0d, expected 16", tx_seen.size()); end
        for (int i = 0; i < 16; i++) begin
            got = (i < tx_seen.size()) ? tx_seen[i] : 8'hXX;
            n_compared++;
            if (got !== 8'(i + 1)) begin n_mismatched++; $display("[TB] FAIL drain[%0d]: got 0x%02h, expected 0x%02h", i, got, 8'(i + 1)); end
        end
        bus_read(32'h0000_0100, rd);
        n_compared++;
        if (rd !== 8'h11) begin n_mismatched++; $display("[TB] FAIL ram_wr_while_stalled: got 0x%02h, expected 0x11", rd); end
    endtask

    task automatic test_rx();
        logic [7:0] rd;
        do_reset();
        rx_valid = 1'b1;
        rx_data  = 8'h31;
        idle_cycles(1);
        rx_data  = 8'h32;
        idle_cycles(1);
        rx_valid = 1'b0;
        bus_read(32'h0003_0001, rd);
        n_compared++;
        if (rd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL io_rd_30001: got 0x%02h, expected 0x00", rd); end
        bus_read(32'h0003_0000, rd);
        n_compared++;
        if (rd !== 8'h31) begin n_mismatched++; $display("[TB] FAIL rx_rd_1: got 0x%02h, expected 0x31", rd); end
        bus_read(32'h0003_0000, rd);
        n_compared++;
        if (rd !== 8'h32) begin n_mismatched++; $display("[TB] FAIL rx_rd_2: got 0x%02h, expected 0x32", rd); end
        bus_read(32'h0003_0000, rd);
        n_compared++;
        if (rd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL rx_rd_empty: got 0x%02h, expected 0x00", rd); end
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        bus_read(32'h0003_0000, rd);
        rx_valid = 1'b0;
        n_compared++;
        if (rd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL rx_empty_with_push: got 0x%02h, expected 0x00", rd); end
        bus_read(32'h0003_0000, rd);
        n_compared++;
        if (rd !== 8'h55) begin n_mismatched++; $display("[TB] FAIL rx_pushed_kept: got 0x%02h, expected 0x55", rd); end
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'h40 + 8'(i);
            idle_cycles(1);
        end
        n_compared++;
        if (rx_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rx_full_ready: got %b, expected 0", rx_ready); end
        rx_data = 8'h99;
        idle_cycles(1);
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_read(32'h0003_0000, rd);
            n_compared++;
            if (rd !== 8'h40 + 8'(i)) begin n_mismatched++; $display("[TB] FAIL rx_full_rd[%0d]: got 0x%02h, expected 0x%02h", i, rd, 8'h40 + 8'(i)); end
        end
        bus_read(32'h0003_0000, rd);
        n_compared++;
        if (rd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL rx_overflow_dropped: got 0x%02h, expected 0x00", rd); end
    endtask

    task automatic test_counter();
        logic [7:0] rd;
        logic [7:0] exp_b [4];
        // No snapshot yet: live counter is 299 (0x12B) but byte 1 must read 0.
        do_reset();
        idle_cycles(299);
        bus_read(32'h0003_0005, rd);
        n_compared++;
        if (rd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL cnt_no_snapshot: got 0x%02h, expected 0x00", rd); end
        // Snapshot 255 (0xFF); live byte 1 becomes 0x01 one cycle later.
        do_reset();
        idle_cycles(255);
        bus_read(32'h0003_0004, rd);
        n_compared++;
        if (rd !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL cnt255_b0: got 0x%02h, expected 0xff", rd); end
        bus_read(32'h0003_0005, rd);
        n_compared++;
        if (rd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL cnt255_b1: got 0x%02h, expected 0x00", rd); end
        bus_read(32'h0003_0006, rd);
        bus_read(32'h0003_0007, rd);
        // Byte-0 read on the 1000th edge after reset sees 999 = 0x3E7.
        idle_cycles(740);
        exp_b[0] = 8'hE7; exp_b[1] = 8'h03; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            bus_read(32'h0003_0004 + 32'(i), rd);
            n_compared++;
            if (rd !== exp_b[i]) begin n_mismatched++; $display("[TB] FAIL cnt999_b%0d: got 0x%02h, expected 0x%02h", i, rd, exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        do_reset();
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        bus_write(32'h0003_0000, 8'hC1);
        rx_valid = 1'b0;
        for (int i = 2; i <= 5; i++) bus_write(32'h0003_0000, 8'hC0 + 8'(i));
        idle_cycles(4655);
        bus_read(32'h0003_0004, rd);
        n_compared++;
        if (rd !== 8'h34) begin n_mismatched++; $display("[TB] FAIL cnt1234_b0: got 0x%02h, expected 0x34", rd); end
        bus_read(32'h0003_0005, rd);
        n_compared++;
        if (rd !== 8'h12) begin n_mismatched++; $display("[TB] FAIL cnt1234_b1: got 0x%02h, expected 0x12", rd); end
        bus_read(32'h0000_1234, rd);
        n_compared++;
        if (tx_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pre_reset_tx_valid: got %b, expected 1", tx_valid); end
        do_reset();
        n_compared++;
        if (tx_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_tx_valid: got %b, expected 0", tx_valid); end
        n_compared++;
        if (cpu_din !== 8'h00) begin n_mismatched++; $display("[TB] FAIL mid_reset_cpu_din: got 0x%02h, expected 0x00", cpu_din); end
        bus_read(32'h0003_0000, rd);
        n_compared++;
        if (rd !== 8'h00) begin n_mismatched++; $display("[TB] FAIL mid_reset_rx_flushed: got 0x%02h, expected 0x00", rd); end
        bus_read(32'h0003_0004, rd);
        n_compared++;
        if (rd !== 8'h01) begin n_mismatched++; $display("[TB] FAIL mid_reset_cnt_restart: got 0x%02h, expected 0x01", rd); end
    endtask

    // Test sequence; RAM contents written by test_ram persist across resets.
    initial begin
        rst_in   = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        bus_idle();
        test_reset();
        test_ram();
        test_tx_and_stop();
        test_tx_full();
        test_rx();
        test_counter();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
